// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the processor control unit sequencer.
// Holds the FSM state encoding, fetch micro-indices and the opcode length table.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StHalted
   } seq_state_e;

   localparam int unsigned OP_HALT   = 0;
   localparam int unsigned OP_L1A_LO = 36;
   localparam int unsigned OP_L1A_HI = 51;
   localparam int unsigned OP_L1B_LO = 54;
   localparam int unsigned OP_L1B_HI = 56;

   // mIR for fetch step 0, 1, 2
   localparam int unsigned UI_FETCH0 = 1;
   localparam int unsigned UI_FETCH1 = 2;
   localparam int unsigned UI_FETCH2 = 3;

   // Number of execute micro-steps for an opcode; 0 means not executable.
   function automatic logic [2:0] op_len(input int unsigned op);
      case (op)
         4, 8:                     return 3'd4;
         18, 21, 24, 27, 30, 33:   return 3'd3;
         12, 14, 16, 52:           return 3'd2;
         default: begin
            if ((op >= OP_L1A_LO && op <= OP_L1A_HI) || (op >= OP_L1B_LO && op <= OP_L1B_HI)) begin
               return 3'd1;
            end
            return 3'd0;
         end
      endcase
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Control/status bundle between the instruction controller and the micro-sequencer.
// master drives start/stall/opcode; slave (the sequencer) drives the status outputs.
interface micro_sequencer_if #(
   parameter int unsigned OPW = 6,
   parameter int unsigned UAW = 6
);
   logic           start;
   logic           stall;
   logic [OPW-1:0] opcode;
   logic [UAW-1:0] mIR;
   logic           ir_load;
   logic           done;
   logic           busy;
   logic           halted;
   logic           illegal;

   modport master (
      output start, stall, opcode,
      input  mIR, ir_load, done, busy, halted, illegal
   );

   modport slave (
      input  start, stall, opcode,
      output mIR, ir_load, done, busy, halted, illegal
   );
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: legality, HALT detection and execute length.
module opcode_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW = 6
) (
   input  logic [OPW-1:0] opcode,
   output logic           legal,
   output logic           is_halt,
   output logic [2:0]     len
);
   always_comb begin
      len     = op_len(32'(opcode));
      legal   = (len != 3'd0);
      is_halt = (opcode == OPW'(OP_HALT));
   end
endmodule

// File: rtl/micro_sequencer.sv
// Fetch/decode/execute micro-sequencer: walks fetch steps, decodes the opcode
// once, then steps mIR through base..base+len-1 with stall, halt and illegal handling.
module micro_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW = 6,
   parameter int unsigned UAW = 6
) (
   input logic              clk,
   input logic              rst,
   micro_sequencer_if.slave bus
);
   seq_state_e     state_q, state_d;
   logic [1:0]     step_q, step_d, step_inc;
   logic [UAW-1:0] base_q, base_d;
   logic [2:0]     len_q, len_d;
   logic [UAW-1:0] mir_q, mir_d;
   logic           ir_load_q, ir_load_d;
   logic           done_q, done_d;
   logic           illegal_q, illegal_d;
   logic           dec_legal, dec_is_halt;
   logic [2:0]     dec_len;
   logic           active, dec_bad, exec_last;

   opcode_decode #(.OPW(OPW)) u_decode (
      .opcode  (bus.opcode),
      .legal   (dec_legal),
      .is_halt (dec_is_halt),
      .len     (dec_len)
   );

   assign active    = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
   assign step_inc  = step_q + 2'd1;
   assign exec_last = ({1'b0, step_q} == len_q - 3'd1);
   // The opcode is only valid during DECODE, so an illegal opcode must be
   // flagged in that same cycle rather than on the following edge.
   assign dec_bad   = (state_q == StDecode) && !dec_legal && !dec_is_halt;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      base_d    = base_q;
      len_d     = len_q;
      mir_d     = mir_q;
      ir_load_d = ir_load_q;
      done_d    = done_q;
      illegal_d = illegal_q;
      if (!(active && bus.stall)) begin
         unique case (state_q)
            StIdle, StHalted: begin
               if (bus.start) begin
                  state_d = StFetch;
                  step_d  = 2'd0;
                  mir_d   = UAW'(UI_FETCH0);
               end
            end
            StFetch: begin
               if (step_q == 2'd0) begin
                  step_d = step_inc;
                  mir_d  = UAW'(UI_FETCH1);
               end else if (step_q == 2'd1) begin
                  step_d    = step_inc;
                  mir_d     = UAW'(UI_FETCH2);
                  ir_load_d = 1'b1;
               end else begin
                  state_d   = StDecode;
                  step_d    = 2'd0;
                  mir_d     = '0;
                  ir_load_d = 1'b0;
               end
            end
            StDecode: begin
               base_d = UAW'(bus.opcode);
               len_d  = dec_len;
               step_d = 2'd0;
               if (dec_is_halt) begin
                  state_d = StHalted;
                  mir_d   = '0;
               end else if (!dec_legal) begin
                  state_d   = StFetch;
                  mir_d     = UAW'(UI_FETCH0);
                  illegal_d = 1'b1;
               end else begin
                  state_d = StExec;
                  mir_d   = UAW'(bus.opcode);
                  done_d  = (dec_len == 3'd1);
               end
            end
            StExec: begin
               if (exec_last) begin
                  state_d = StFetch;
                  step_d  = 2'd0;
                  mir_d   = UAW'(UI_FETCH0);
                  done_d  = 1'b0;
               end else begin
                  step_d = step_inc;
                  mir_d  = base_q + UAW'(step_inc);
                  done_d = ({1'b0, step_inc} == len_q - 3'd1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         step_q    <= 2'd0;
         base_q    <= '0;
         len_q     <= 3'd0;
         mir_q     <= '0;
         ir_load_q <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         base_q    <= base_d;
         len_q     <= len_d;
         mir_q     <= mir_d;
         ir_load_q <= ir_load_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.mIR     = mir_q;
   assign bus.ir_load = ir_load_q;
   assign bus.done    = done_q | dec_bad;
   assign bus.busy    = active;
   assign bus.halted  = (state_q == StHalted);
   assign bus.illegal = illegal_q | dec_bad;
endmodule
